// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: the bus bundle of the load/store unit.
//   Request channel  : req_valid/req_ready handshake, req_we, req_funct3,
//                      req_addr (byte address), req_wdata (right-aligned).
//   Response channel : rsp_valid/rsp_ready handshake, rsp_rdata, rsp_err.
//   Memory port      : mem_we, mem_a (word index), mem_wd, mem_rd
//                      (combinational read data for mem_a).
// The slave modport is the unit itself; the master modport is its
// environment (the core's memory stage together with the data memory).
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output rsp_ready, mem_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_we, mem_a, mem_wd
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  rsp_ready, mem_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit in front of a single-port, word-addressed data
// memory of MEM_SIZE 32-bit words.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : dmem_lsu_if.slave
//     req_*  byte-addressed RISC-V load/store request (valid/ready)
//     rsp_*  response with extended load data and error flag (valid/ready)
//     mem_*  word access to the data memory
// Loads take one memory cycle, word stores one write cycle, and byte or
// halfword stores a read cycle followed by a merged write cycle. Malformed
// requests (misaligned, out of range, illegal funct3) go straight to the
// response with rsp_err set and never touch the memory.
// Every output is a register, so nothing on req_* or rsp_ready reaches an
// output combinationally.
module dmem_lsu #(
  parameter int MEM_SIZE = 64
) (
  input  logic     clk,
  input  logic     reset,
  dmem_lsu_if.slave bus
);

  localparam logic [29:0] MEM_WORDS = 30'(MEM_SIZE);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR,
    RESP
  } state_t;

  state_t      state;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic        mem_we_q;
  logic [31:0] mem_a_q;
  logic [31:0] mem_wd_q;

  // Request legality: misaligned H/W access, word index beyond the memory,
  // reserved funct3 encodings, and unsigned sizes used with a store.
  function automatic logic req_error(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr);
    logic bad_f3;
    logic misaligned;
    logic out_of_range;
    bad_f3       = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
                   (we && f3[2]);
    misaligned   = ((f3[1:0] == 2'b01) && addr[0]) ||
                   ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    out_of_range = (addr[31:2] >= MEM_WORDS);
    return bad_f3 || misaligned || out_of_range;
  endfunction

  // Pick the addressed byte/halfword out of a little-endian word and extend
  // it to 32 bits according to funct3.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0] f3,
                                              input logic [1:0] lane);
    logic [31:0]        shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic [31:0]        result;
    shifted = word >> {lane, 3'b000};
    byte_s  = shifted[7:0];
    half_s  = shifted[15:0];
    case (f3)
      F3_B:    result = {{24{byte_s[7]}}, byte_s};
      F3_H:    result = {{16{half_s[15]}}, half_s};
      F3_BU:   result = {24'h0, shifted[7:0]};
      F3_HU:   result = {16'h0, shifted[15:0]};
      default: result = word;
    endcase
    return result;
  endfunction

  // Replace the addressed byte (half=0) or halfword (half=1) of the old word
  // with the low bits of the store data; the other lanes pass through.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [15:0] wd,
                                              input logic half,
                                              input logic [1:0] lane);
    logic [31:0] mask;
    logic [31:0] data;
    mask = (half ? 32'h0000_FFFF : 32'h0000_00FF) << {lane, 3'b000};
    data = {16'h0, wd} << {lane, 3'b000};
    return (old_word & ~mask) | (data & mask);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      funct3_q    <= 3'b000;
      lane_q      <= 2'b00;
      wdata_q     <= 16'h0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_a_q     <= 32'h0;
      mem_wd_q    <= 32'h0;
    end else begin
      case (state)
        // Accept: latch the request and route it.
        IDLE: begin
          if (bus.req_valid) begin
            funct3_q    <= bus.req_funct3;
            lane_q      <= bus.req_addr[1:0];
            wdata_q     <= bus.req_wdata[15:0];
            mem_a_q     <= {2'b00, bus.req_addr[31:2]};
            req_ready_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            if (req_error(bus.req_we, bus.req_funct3, bus.req_addr)) begin
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state       <= RESP;
            end else begin
              rsp_err_q <= 1'b0;
              if (!bus.req_we) begin
                state <= LOAD;
              end else if (bus.req_funct3 == F3_W) begin
                // Full word: write straight away, no read needed.
                mem_we_q <= 1'b1;
                mem_wd_q <= bus.req_wdata;
                state    <= STORE;
              end else begin
                state <= RMW_RD;
              end
            end
          end
        end

        // Load: memory read data for the latched index is valid now.
        LOAD: begin
          rsp_rdata_q <= load_extend(bus.mem_rd, funct3_q, lane_q);
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end

        // Word store commits on this edge.
        STORE: begin
          mem_we_q    <= 1'b0;
          mem_wd_q    <= 32'h0;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end

        // Sub-word store, read half: capture the old word already merged
        // with the new lane(s); mem_wd is the merge register.
        RMW_RD: begin
          mem_wd_q <= store_merge(bus.mem_rd, wdata_q, funct3_q[0], lane_q);
          mem_we_q <= 1'b1;
          state    <= RMW_WR;
        end

        // Sub-word store, write half commits on this edge.
        RMW_WR: begin
          mem_we_q    <= 1'b0;
          mem_wd_q    <= 32'h0;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end

        // Response: hold until the core takes it.
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          mem_we_q    <= 1'b0;
          mem_wd_q    <= 32'h0;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_a     = mem_a_q;
  assign bus.mem_wd    = mem_wd_q;

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit: the initiator side of the single-port, word-addressed data memory. It accepts byte-addressed RISC-V load/store requests from the core over a valid/ready handshake and converts them into word accesses on the memory port. It performs byte/halfword extraction with sign- or zero-extension on loads, and a two-cycle read-modify-write for sub-word stores. It sits between the core's memory stage and the data memory; responses return on a separate valid/ready channel.

## Interface
- MEM_SIZE, 64: memory depth in 32-bit words; word index must be < MEM_SIZE.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response valid; held until rsp_ready.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request was misaligned, out of range or had an illegal funct3.
- mem_we  out  1  memory write enable.
- mem_a  out  32  memory word index, equal to the latched byte address >> 2.
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory read data; combinational from mem_a.

## Operation
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- IDLE: req_ready=1. On req_valid, latch we, funct3, addr and wdata, then check for errors:
  - Misaligned: H with addr[0]≠0; W with addr[1:0]≠0.
  - Out of range: addr[31:2] ≥ MEM_SIZE.
  - Illegal funct3: 011, 110 or 111; store with funct3[2]=1.
  - Any error → RESP with rsp_err=1, rsp_rdata=0. The memory is never written.
- Legal request routing: load → LOAD; SW → STORE; SB/SH → RMW_RD.
- LOAD: drive mem_a and capture mem_rd.
  - Byte lanes are little-endian: lane k = bits 8k+7:8k, selected by addr[1:0].
  - B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
  - Result registered into rsp_rdata → RESP.
- STORE: mem_we=1, mem_wd=wdata → RESP.
- RMW_RD: capture mem_rd into a merge register → RMW_WR.
- RMW_WR: mem_we=1; mem_wd = merge register with wdata[7:0] (SB) or wdata[15:0] (SH) placed in the addressed lane(s); other bytes are unchanged → RESP.
- RESP: rsp_valid=1, and rsp_rdata/rsp_err hold stable. On rsp_ready → IDLE, with rsp_valid low the next cycle.
- Outside active states:
  - mem_a holds the latched index; it is 0 after reset.
  - mem_wd is 0 outside STORE and RMW_WR.
  - mem_we is 1 only in STORE and RMW_WR.

## Timing
- All outputs are decoded from registered state and registers; there is no combinational path from req_* or rsp_ready to any output.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_a=0, mem_wd=0, state IDLE.
- Latency from the accept edge (cycle N) to the first cycle with rsp_valid high:
  - Error: N+1.
  - Load or SW: N+2.
  - SB/SH: N+3.
- Throughput: at most one request in flight. A new request is accepted only in IDLE, i.e. no earlier than the cycle after the rsp_valid&rsp_ready handshake.
- The memory write commits on the clock edge that ends STORE or RMW_WR.
- Response back-pressure: rsp_valid stays high with stable data for any number of cycles while rsp_ready=0.
- Request held while the unit is busy: req_valid may stay high; it is ignored until IDLE and then accepted once.
- Reset mid-operation: state is forced to IDLE immediately and mem_we drops asynchronously, so no partial RMW write occurs. The pending response is discarded.

## Test plan
- Word load: word 1 preloaded with 0x000239DF; LW addr 0x4 → rsp_rdata 0x000239DF, rsp_err=0, rsp_valid at N+2.
- Signed/unsigned byte load: word 2 = 0x000231DF.
  - LB addr 0x8 → 0xFFFFFFDF.
  - LBU addr 0x8 → 0x000000DF.
  - LH addr 0xA → 0x00000002.
- Sub-word store RMW: word 3 = 0x000011DF; SB addr 0xD, wdata 0xAB → word 3 = 0x0000ABDF, with exactly one mem_we pulse at N+2 and rsp_valid at N+3.
- Error cases: each of the following gives rsp_err=1 at N+1 and mem_we never asserted:
  - LW addr 0x6 (misaligned).
  - SW addr 4*MEM_SIZE (out of range).
  - funct3 110 (illegal).
- Back-pressure: rsp_ready held low 5 cycles, with req_valid held high carrying a second request.
  - rsp_valid and rsp_rdata stay stable.
  - The second request is accepted only after the handshake.
- Reset during RMW_RD of SH addr 0x10 → mem_we stays 0, word 4 unchanged, and all outputs return to reset values.
